fetch_pc_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the fetch/decode pipeline latch.
- Owns the program counter and drives the instruction-cache request (imemREN/imemaddr).
- Accepts redirects (branch/jump resolution), hazard stalls and halt from later stages.
- Produces the update/flush controls and the instruction / PC+4 / next-PC data that the fetch/decode latch captures.

---
 rtl/fetch_pc_unit_if.sv | 33 +++
 rtl/fetch_pc_unit.sv | 122 ++++++++++++
 tb/tb_fetch_pc_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_unit_if.sv
// Bus between the fetch PC unit and its environment: icache request/response,
// hazard/redirect/halt controls, and the fetch/decode latch feed.
interface fetch_pc_unit_if #(
    parameter int unsigned WORD_W = 32
);
    logic              ihit;
    logic [WORD_W-1:0] imemload;
    logic              imemREN;
    logic [WORD_W-1:0] imemaddr;
    logic              stall;
    logic              redirect_valid;
    logic [WORD_W-1:0] redirect_pc;
    logic              halt;
    logic              fd_update;
    logic              fd_flush;
    logic [WORD_W-1:0] fd_instruction;
    logic [WORD_W-1:0] fd_normal_pc;
    logic [WORD_W-1:0] fd_next_pc;

    // Environment side: drives cache responses and pipeline controls.
    modport master (
        output ihit, imemload, stall, redirect_valid, redirect_pc, halt,
        input  imemREN, imemaddr, fd_update, fd_flush,
        input  fd_instruction, fd_normal_pc, fd_next_pc
    );

    // Fetch unit side.
    modport slave (
        input  ihit, imemload, stall, redirect_valid, redirect_pc, halt,
        output imemREN, imemaddr, fd_update, fd_flush,
        output fd_instruction, fd_normal_pc, fd_next_pc
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, issues icache reads and feeds the
// fetch/decode latch with update/flush controls and instruction/PC data.
module fetch_pc_unit #(
    parameter int unsigned         WORD_W  = 32,
    parameter logic [WORD_W-1:0]   PC_INIT = 32'h00000000
) (
    input  logic                   CLK,
    input  logic                   RST,
    fetch_pc_unit_if.slave         bus
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [WORD_W-1:0] PC_STEP    = WORD_W'(4);
    localparam logic [WORD_W-1:0] ALIGN_MASK = ~(WORD_W'(3));

    state_t            state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] pend_pc_q, pend_pc_d;

    logic              imem_ren_s;
    logic              fd_update_s;
    logic              fd_flush_s;
    logic [WORD_W-1:0] redirect_aligned_s;
    logic [WORD_W-1:0] pc_plus4_s;

    // Branch targets always land on a word boundary.
    function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

    // State, PC and pending-redirect registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_FETCH;
            pc_q      <= PC_INIT;
            pend_pc_q <= {WORD_W{1'b0}};
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    // Next state, next PC and latch controls; halt > redirect > stall > ihit.
    always_comb begin
        state_d            = state_q;
        pc_d               = pc_q;
        pend_pc_d          = pend_pc_q;
        imem_ren_s         = 1'b1;
        fd_update_s        = 1'b0;
        fd_flush_s         = 1'b0;
        redirect_aligned_s = align_word(bus.redirect_pc);
        pc_plus4_s         = pc_q + PC_STEP;

        case (state_q)
            ST_FETCH: begin
                if (bus.halt) begin
                    state_d    = ST_HALTED;
                    fd_flush_s = 1'b1;
                end else if (bus.redirect_valid) begin
                    fd_flush_s = 1'b1;
                    if (bus.ihit) begin
                        pc_d = redirect_aligned_s;
                    end else begin
                        // Miss in flight at pc: hold the address until it returns.
                        pend_pc_d = redirect_aligned_s;
                        state_d   = ST_DRAIN;
                    end
                end else if (bus.stall) begin
                    pc_d = pc_q;
                end else if (bus.ihit) begin
                    fd_update_s = 1'b1;
                    pc_d        = pc_plus4_s;
                end else begin
                    pc_d = pc_q;
                end
            end

            ST_DRAIN: begin
                if (bus.halt) begin
                    state_d = ST_HALTED;
                end else begin
                    if (bus.redirect_valid) begin
                        pend_pc_d = redirect_aligned_s;
                    end else begin
                        pend_pc_d = pend_pc_q;
                    end
                    // Wrong-path word is dropped; resume at the newest target.
                    if (bus.ihit) begin
                        pc_d    = bus.redirect_valid ? redirect_aligned_s : pend_pc_q;
                        state_d = ST_FETCH;
                    end else begin
                        pc_d = pc_q;
                    end
                end
            end

            ST_HALTED: begin
                imem_ren_s = 1'b0;
            end

            default: begin
                imem_ren_s = 1'b0;
                state_d    = ST_FETCH;
            end
        endcase
    end

    assign bus.imemREN        = imem_ren_s;
    assign bus.imemaddr       = pc_q;
    assign bus.fd_update      = fd_update_s;
    assign bus.fd_flush       = fd_flush_s;
    assign bus.fd_instruction = bus.imemload;
    assign bus.fd_normal_pc   = pc_plus4_s;
    assign bus.fd_next_pc     = pc_d;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: a default-reset instance and a wrap
// instance (PC_INIT = 0xFFFFFFFC) share clock, reset and stimulus.
module tb_fetch_pc_unit;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    fetch_pc_unit_if #(.WORD_W(32)) bus_a ();
    fetch_pc_unit_if #(.WORD_W(32)) bus_b ();

    fetch_pc_unit #(.WORD_W(32), .PC_INIT(32'h00000000)) u_dut_a (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_a)
    );

    fetch_pc_unit #(.WORD_W(32), .PC_INIT(32'hFFFFFFFC)) u_dut_b (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_b)
    );

    typedef struct {
        logic        sel;
        logic        ren;
        logic [31:0] addr;
        logic        upd;
        logic        flush;
        logic [31:0] npc;
        logic [31:0] nxt;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic set_inputs(input logic ihit, input logic [31:0] load, input logic stall,
                              input logic rv, input logic [31:0] rpc, input logic halt);
        bus_a.ihit = ihit;  bus_a.imemload = load;  bus_a.stall = stall;
        bus_a.redirect_valid = rv;  bus_a.redirect_pc = rpc;  bus_a.halt = halt;
        bus_b.ihit = ihit;  bus_b.imemload = load;  bus_b.stall = stall;
        bus_b.redirect_valid = rv;  bus_b.redirect_pc = rpc;  bus_b.halt = halt;
    endtask

    // Drive one cycle of inputs, queue the expected outputs, then compare.
    task automatic step(input string tag, input logic sel,
                        input logic ihit, input logic [31:0] load, input logic stall,
                        input logic rv, input logic [31:0] rpc, input logic halt,
                        input logic e_ren, input logic [31:0] e_addr,
                        input logic e_upd, input logic e_flush, input logic [31:0] e_nxt);
        exp_t e;
        exp_t g;
        @(negedge CLK);
        set_inputs(ihit, load, stall, rv, rpc, halt);
        e.sel = sel;  e.ren = e_ren;  e.addr = e_addr;  e.upd = e_upd;
        e.flush = e_flush;  e.npc = e_addr + 32'd4;  e.nxt = e_nxt;  e.instr = load;
        exp_q.push_back(e);
        #1;
        g = exp_q.pop_front();
        if (g.sel) begin
            check_eq({tag, ".ren"},   {31'd0, bus_b.imemREN},   {31'd0, g.ren});
            check_eq({tag, ".addr"},  bus_b.imemaddr,           g.addr);
            check_eq({tag, ".upd"},   {31'd0, bus_b.fd_update}, {31'd0, g.upd});
            check_eq({tag, ".flush"}, {31'd0, bus_b.fd_flush},  {31'd0, g.flush});
            check_eq({tag, ".npc"},   bus_b.fd_normal_pc,       g.npc);
            check_eq({tag, ".nxt"},   bus_b.fd_next_pc,         g.nxt);
            check_eq({tag, ".instr"}, bus_b.fd_instruction,     g.instr);
        end else begin
            check_eq({tag, ".ren"},   {31'd0, bus_a.imemREN},   {31'd0, g.ren});
            check_eq({tag, ".addr"},  bus_a.imemaddr,           g.addr);
            check_eq({tag, ".upd"},   {31'd0, bus_a.fd_update}, {31'd0, g.upd});
            check_eq({tag, ".flush"}, {31'd0, bus_a.fd_flush},  {31'd0, g.flush});
            check_eq({tag, ".npc"},   bus_a.fd_normal_pc,       g.npc);
            check_eq({tag, ".nxt"},   bus_a.fd_next_pc,         g.nxt);
            check_eq({tag, ".instr"}, bus_a.fd_instruction,     g.instr);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        set_inputs(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        set_inputs(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        do_reset();

        // sequential fetch
        step("rst",  1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        step("seq0", 1'b0, 1'b1, 32'hA0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0,  1'b1, 1'b0, 32'h4);
        step("seq1", 1'b0, 1'b1, 32'hA1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4,  1'b1, 1'b0, 32'h8);
        step("seq2", 1'b0, 1'b1, 32'hA2, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8,  1'b1, 1'b0, 32'hC);
        step("seq3", 1'b0, 1'b1, 32'hA3, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC,  1'b1, 1'b0, 32'h10);

        // miss at pc=8
        do_reset();
        step("m0",   1'b0, 1'b1, 32'hB0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h4);
        step("m1",   1'b0, 1'b1, 32'hB1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 32'h8);
        for (int i = 0; i < 3; i++)
            step("miss", 1'b0, 1'b0, 32'hBAD, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 32'h8);
        step("mhit", 1'b0, 1'b1, 32'hB2, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8, 1'b1, 1'b0, 32'hC);
        step("mpost",1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC, 1'b0, 1'b0, 32'hC);

        // stall at 0x20
        step("r20",  1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h20, 1'b0, 1'b1, 32'hC, 1'b0, 1'b1, 32'h20);
        for (int i = 0; i < 2; i++)
            step("stall", 1'b0, 1'b1, 32'hC0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 32'h20);
        step("strel",1'b0, 1'b1, 32'hC1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 32'h24);
        step("stpost",1'b0,1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h24, 1'b0, 1'b0, 32'h24);

        // redirect with hit, unaligned target
        step("r40",  1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h40,  1'b0, 1'b1, 32'h24, 1'b0, 1'b1, 32'h40);
        step("rhit", 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h103, 1'b0, 1'b1, 32'h40, 1'b0, 1'b1, 32'h100);
        step("rhpost",1'b0,1'b0, 32'h0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h100);

        // redirect with miss -> drain, newer redirect wins
        step("r40b", 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h40,  1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 32'h40);
        step("rmiss",1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h103, 1'b0, 1'b1, 32'h40, 1'b0, 1'b1, 32'h40);
        step("dr200",1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h40);
        step("drhit",1'b0, 1'b1, 32'hDEAD, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h200);
        step("d200", 1'b0, 1'b1, 32'hD0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 32'h204);
        step("rm300",1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h300, 1'b0, 1'b1, 32'h204, 1'b0, 1'b1, 32'h204);
        step("drhr", 1'b0, 1'b1, 32'hBEEF, 1'b0, 1'b1, 32'h406, 1'b0, 1'b1, 32'h204, 1'b0, 1'b0, 32'h404);
        step("d404", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h404, 1'b0, 1'b0, 32'h404);

        // halt at 0x50
        step("r50",  1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h50,  1'b0, 1'b1, 32'h404, 1'b0, 1'b1, 32'h50);
        step("halt", 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h80,  1'b1, 1'b1, 32'h50, 1'b0, 1'b1, 32'h50);
        for (int i = 0; i < 2; i++)
            step("hltd", 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h80, 1'b0, 1'b0, 32'h50, 1'b0, 1'b0, 32'h50);
        do_reset();
        step("hrst", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);

        // halt while draining, then reset out of it
        step("dh0",  1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h10, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0);
        step("dh1",  1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        step("dh2",  1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        do_reset();

        // wrap on the PC_INIT = 0xFFFFFFFC instance
        step("wrap0",1'b1, 1'b1, 32'hE0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFFFFFC, 1'b1, 1'b0, 32'h0);
        step("wrap1",1'b1, 1'b1, 32'hE1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 32'h4);

        check_eq("sb_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
